// File: rtl/store_buffer.sv
// ============================================================================
// store_buffer
//   Retires core stores into a small circular FIFO and drains them one entry
//   at a time to main memory over a req/ack handshake. Younger loads are
//   checked against the buffered entries so they observe stores that have
//   not yet reached memory.
//
//   Build option:
//     STORE_FWD_EN  defined   -> store-to-load data forwarding is present.
//                   undefined -> no forwarding; any address-word match on a
//                                buffered entry raises fwd_conflict so the
//                                core stalls until that entry drains.
// ============================================================================
module store_buffer #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   // store port from the core
   input  logic                     st_valid,
   output logic                     st_ready,
   input  logic [DATA_WIDTH-1:0]    st_addr,
   input  logic [DATA_WIDTH-1:0]    st_data,
   input  logic                     st_byte,
   // flush control
   input  logic                     flush,
   output logic                     flush_done,
   // load forwarding lookup
   input  logic [DATA_WIDTH-1:0]    ld_addr,
   input  logic                     ld_byte,
   output logic                     fwd_hit,
   output logic [DATA_WIDTH-1:0]    fwd_data,
   output logic                     fwd_conflict,
   // memory write port
   output logic                     mem_req,
   input  logic                     mem_ack,
   output logic [DATA_WIDTH-1:0]    mem_addr,
   output logic [DATA_WIDTH-1:0]    mem_wdata,
   output logic                     mem_byte,
   // occupancy
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic {
      S_RUN   = 1'b0,
      S_FLUSH = 1'b1
   } state_t;

   // ---------------------------------------------------------------------
   // Entry storage and queue bookkeeping
   // ---------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] r_addr [DEPTH];
   logic [DATA_WIDTH-1:0] r_data [DEPTH];
   logic [DEPTH-1:0]      r_byte;
   logic [DEPTH-1:0]      r_valid;

   logic [PTR_W-1:0]      r_head;
   logic [PTR_W-1:0]      r_tail;
   logic [CNT_W-1:0]      r_count;
   logic                  r_empty;
   logic                  r_full;

   state_t                r_state;
   state_t                w_state_next;
   logic                  r_flush_done;
   logic                  w_flush_done_next;

   logic                  w_st_ready;
   logic                  w_push;
   logic                  w_pop;
   logic [CNT_W-1:0]      w_count_next;

   // Handshake qualifiers: a push needs a free slot and RUN; a pop needs a
   // live head entry, so an ack with no request is ignored.
   assign w_push = st_valid && w_st_ready;
   assign w_pop  = !r_empty && mem_ack;

   // Occupancy after this edge; shared by the flags and the flush FSM.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // through the block leaves it unassigned (which would infer a latch).
      w_count_next = r_count;
      unique case ({w_push, w_pop})
         2'b10:   w_count_next = r_count + CNT_W'(1);
         2'b01:   w_count_next = r_count - CNT_W'(1);
         default: w_count_next = r_count;
      endcase
   end

   // Entry payload write at the tail.
   // NOTE: the payload array is deliberately not reset; r_valid gates every
   // use of it, so clearing the data would only cost reset fan-out.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_addr[r_tail] <= st_addr;
         r_data[r_tail] <= st_data;
         r_byte[r_tail] <= st_byte;
      end
   end

   // Pointers, per-entry valid bits and registered occupancy flags.
   always_ff @(posedge clk) begin
      // NOTE: sequential state is updated with non-blocking assignments so
      // every flop samples pre-edge values regardless of statement order.
      if (!rst_n) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_empty <= 1'b1;
         r_full  <= 1'b0;
         r_valid <= '0;
      end else begin
         if (w_push) begin
            r_tail          <= r_tail + PTR_W'(1);
            r_valid[r_tail] <= 1'b1;
         end
         if (w_pop) begin
            r_head          <= r_head + PTR_W'(1);
            r_valid[r_head] <= 1'b0;
         end
         r_count <= w_count_next;
         r_empty <= (w_count_next == '0);
         r_full  <= (w_count_next == CNT_W'(DEPTH));
      end
   end

   // ---------------------------------------------------------------------
   // Flush FSM
   // ---------------------------------------------------------------------

   // State register, plus the registered flush_done pulse.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= S_RUN;
         r_flush_done <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_flush_done <= w_flush_done_next;
      end
   end

   // Next state: leave FLUSH on the edge the buffer is (or becomes) empty.
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         S_RUN:   if (flush)               w_state_next = S_FLUSH;
         S_FLUSH: if (w_count_next == '0)  w_state_next = S_RUN;
         default:                          w_state_next = S_RUN;
      endcase
   end

   // State-dependent outputs: stores are refused while flushing.
   always_comb begin
      w_st_ready        = 1'b0;
      w_flush_done_next = 1'b0;
      unique case (r_state)
         S_RUN:   w_st_ready        = !r_full;
         S_FLUSH: w_flush_done_next = (w_count_next == '0);
         default: w_st_ready        = 1'b0;
      endcase
   end

   // ---------------------------------------------------------------------
   // Load forwarding
   // ---------------------------------------------------------------------
`ifdef STORE_FWD_EN
   logic                  w_fwd_hit;
   logic                  w_fwd_conflict;
   logic [DATA_WIDTH-1:0] w_fwd_data;

   // Walk entries youngest-first (tail-1 backwards). A byte entry in a
   // different lane than a byte load is transparent; the first entry that
   // decides the outcome stops the search.
   always_comb begin
      logic                  l_done;
      logic [PTR_W-1:0]      l_idx;
      logic [DATA_WIDTH-1:0] l_shift;
      w_fwd_hit      = 1'b0;
      w_fwd_conflict = 1'b0;
      w_fwd_data     = '0;
      l_done         = 1'b0;
      l_idx          = '0;
      l_shift        = '0;
      for (int k = 0; k < DEPTH; k++) begin
         l_idx = r_tail - PTR_W'(k) - PTR_W'(1);
         if (!l_done && r_valid[l_idx] &&
             (r_addr[l_idx][DATA_WIDTH-1:2] == ld_addr[DATA_WIDTH-1:2])) begin
            if (!r_byte[l_idx]) begin
               // word entry covers every lane
               w_fwd_hit = 1'b1;
               l_done    = 1'b1;
               if (ld_byte) begin
                  l_shift    = r_data[l_idx] >> {ld_addr[1:0], 3'b000};
                  w_fwd_data = {{(DATA_WIDTH-8){1'b0}}, l_shift[7:0]};
               end else begin
                  w_fwd_data = r_data[l_idx];
               end
            end else if (ld_byte) begin
               if (r_addr[l_idx][1:0] == ld_addr[1:0]) begin
                  w_fwd_hit  = 1'b1;
                  w_fwd_data = {{(DATA_WIDTH-8){1'b0}}, r_data[l_idx][7:0]};
                  l_done     = 1'b1;
               end
            end else begin
               // byte entry cannot supply a whole word
               w_fwd_conflict = 1'b1;
               l_done         = 1'b1;
            end
         end
      end
   end

   assign fwd_hit      = w_fwd_hit;
   assign fwd_conflict = w_fwd_conflict;
   assign fwd_data     = w_fwd_data;
`else
   logic w_fwd_conflict;
   logic w_unused_fwd;

   // Without forwarding, any live entry in the same word blocks the load.
   always_comb begin
      w_fwd_conflict = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         if (r_valid[PTR_W'(k)] &&
             (r_addr[PTR_W'(k)][DATA_WIDTH-1:2] == ld_addr[DATA_WIDTH-1:2]))
            w_fwd_conflict = 1'b1;
      end
   end

   // Size and lane of the load do not matter when only stalling.
   assign w_unused_fwd = ^{ld_byte, ld_addr[1:0]};

   assign fwd_hit      = 1'b0;
   assign fwd_conflict = w_fwd_conflict;
   assign fwd_data     = '0;
`endif

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign st_ready   = w_st_ready;
   assign flush_done = r_flush_done;
   assign mem_req    = !r_empty;
   assign mem_addr   = r_addr[r_head];
   assign mem_wdata  = r_data[r_head];
   assign mem_byte   = r_byte[r_head];
   assign count      = r_count;
   assign empty      = r_empty;
   assign full       = r_full;

endmodule

// File: tb/tb_store_buffer.sv
// ============================================================================
// tb_store_buffer
//   Self-checking bench for store_buffer. Memory-side writes are checked
//   against a scoreboard queue filled as stores are accepted; forwarding is
//   checked from a table of load vectors; flush, wrap, same-cycle push/pop
//   and reset-mid-drain are hand-written sequences. Expectations follow the
//   STORE_FWD_EN build option.
// ============================================================================
module tb_store_buffer;

   localparam int DW    = 32;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          st_valid;
   logic          st_ready;
   logic [DW-1:0] st_addr;
   logic [DW-1:0] st_data;
   logic          st_byte;
   logic          flush;
   logic          flush_done;
   logic [DW-1:0] ld_addr;
   logic          ld_byte;
   logic          fwd_hit;
   logic [DW-1:0] fwd_data;
   logic          fwd_conflict;
   logic          mem_req;
   logic          mem_ack;
   logic [DW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_byte;
   logic [$clog2(DEPTH):0] count;
   logic          empty;
   logic          full;

   store_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .st_valid     (st_valid),
      .st_ready     (st_ready),
      .st_addr      (st_addr),
      .st_data      (st_data),
      .st_byte      (st_byte),
      .flush        (flush),
      .flush_done   (flush_done),
      .ld_addr      (ld_addr),
      .ld_byte      (ld_byte),
      .fwd_hit      (fwd_hit),
      .fwd_data     (fwd_data),
      .fwd_conflict (fwd_conflict),
      .mem_req      (mem_req),
      .mem_ack      (mem_ack),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_byte     (mem_byte),
      .count        (count),
      .empty        (empty),
      .full         (full)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [DW-1:0] addr;
      logic [DW-1:0] data;
      logic          is_byte;
   } mem_txn_t;

   typedef struct {
      logic [DW-1:0] ld_addr;
      logic          ld_byte;
      logic          exp_hit;
      logic          exp_conflict;
      logic [DW-1:0] exp_data;
      logic          chk_data;
   } fwd_vec_t;

   mem_txn_t sb_q [$];
   mem_txn_t mon_e;
   fwd_vec_t fwd_tbl [7];
   bit       fwd_en;
   int       pulses;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_store(input logic [DW-1:0] a, input logic [DW-1:0] d,
                              input logic b);
      st_valid = 1'b1;
      st_addr  = a;
      st_data  = d;
      st_byte  = b;
      tick();
      st_valid = 1'b0;
   endtask

   // Scoreboard: record accepted stores, compare every memory handshake.
   // Sampled on the falling edge, half a cycle away from the active edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         sb_q.delete();
      end else begin
         if (mem_req && mem_ack) begin
            if (sb_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL mem_pop: got drain of 0x%08h, expected none", mem_addr);
            end else begin
               mon_e = sb_q.pop_front();
               check("mem_addr",  mem_addr,        mon_e.addr);
               check("mem_wdata", mem_wdata,       mon_e.data);
               check("mem_byte",  32'(mem_byte),   32'(mon_e.is_byte));
            end
         end
         if (st_valid && st_ready)
            sb_q.push_back('{st_addr, st_data, st_byte});
      end
   end

   // Guard against a hung run.
   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, expected finish within 200000 time units");
      $fatal(1, "watchdog expired");
   end

   initial begin
`ifdef STORE_FWD_EN
      fwd_en = 1'b1;
      fwd_tbl[0] = '{32'h21, 1'b1, 1'b1, 1'b0, 32'h0000_00AA, 1'b1};
      fwd_tbl[1] = '{32'h22, 1'b1, 1'b1, 1'b0, 32'h0000_0022, 1'b1};
      fwd_tbl[2] = '{32'h20, 1'b0, 1'b0, 1'b1, 32'h0,         1'b0};
      fwd_tbl[3] = '{32'h20, 1'b1, 1'b1, 1'b0, 32'h0000_0044, 1'b1};
      fwd_tbl[4] = '{32'h23, 1'b1, 1'b1, 1'b0, 32'h0000_0011, 1'b1};
      fwd_tbl[5] = '{32'h24, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1};
      fwd_tbl[6] = '{32'h1F, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1};
`else
      fwd_en = 1'b0;
      fwd_tbl[0] = '{32'h21, 1'b1, 1'b0, 1'b1, 32'h0, 1'b1};
      fwd_tbl[1] = '{32'h22, 1'b1, 1'b0, 1'b1, 32'h0, 1'b1};
      fwd_tbl[2] = '{32'h20, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1};
      fwd_tbl[3] = '{32'h20, 1'b1, 1'b0, 1'b1, 32'h0, 1'b1};
      fwd_tbl[4] = '{32'h23, 1'b1, 1'b0, 1'b1, 32'h0, 1'b1};
      fwd_tbl[5] = '{32'h24, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1};
      fwd_tbl[6] = '{32'h1F, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1};
`endif

      rst_n    = 1'b0;
      st_valid = 1'b0;
      st_addr  = '0;
      st_data  = '0;
      st_byte  = 1'b0;
      flush    = 1'b0;
      ld_addr  = '0;
      ld_byte  = 1'b0;
      mem_ack  = 1'b0;

      // ---------------- reset state ----------------
      repeat (2) tick();
      check("rst_count",      32'(count),      32'd0);
      check("rst_empty",      32'(empty),      32'd1);
      check("rst_full",       32'(full),       32'd0);
      check("rst_mem_req",    32'(mem_req),    32'd0);
      check("rst_flush_done", 32'(flush_done), 32'd0);
      check("rst_st_ready",   32'(st_ready),   32'd1);
      rst_n = 1'b1;

      // ---------------- single store, ack held high ----------------
      mem_ack = 1'b1;
      drive_store(32'h100, 32'hDEAD_BEEF, 1'b0);
      check("t1_mem_req_on",  32'(mem_req), 32'd1);
      check("t1_mem_addr",    mem_addr,     32'h100);
      check("t1_mem_wdata",   mem_wdata,    32'hDEAD_BEEF);
      check("t1_count",       32'(count),   32'd1);
      tick();
      check("t1_mem_req_off", 32'(mem_req), 32'd0);
      check("t1_empty",       32'(empty),   32'd1);
      tick();
      check("t1_idle_ack_count", 32'(count), 32'd0);

      // ---------------- fill, refuse, drain in order (wraps) ----------------
      mem_ack = 1'b0;
      for (int i = 0; i < DEPTH; i++)
         drive_store(32'(i * 4), 32'hA000_0000 + 32'(i), 1'b0);
      check("t2_full",     32'(full),     32'd1);
      check("t2_count",    32'(count),    32'd4);
      check("t2_st_ready", 32'(st_ready), 32'd0);
      check("t2_head",     mem_addr,      32'h0);
      drive_store(32'h10, 32'h0000_0BAD, 1'b0);
      check("t2_refused_count", 32'(count), 32'd4);
      check("t2_head_stable",   mem_addr,   32'h0);
      mem_ack = 1'b1;
      repeat (DEPTH) tick();
      mem_ack = 1'b0;
      check("t2_drained_empty", 32'(empty), 32'd1);
      check("t2_drained_full",  32'(full),  32'd0);

      // ---------------- forwarding table ----------------
      drive_store(32'h20, 32'h1122_3344, 1'b0);
      drive_store(32'h21, 32'h0000_00AA, 1'b1);
      for (int i = 0; i < 7; i++) begin
         ld_addr = fwd_tbl[i].ld_addr;
         ld_byte = fwd_tbl[i].ld_byte;
         #1;
         check($sformatf("fwd_hit[%0d]", i),      32'(fwd_hit),      32'(fwd_tbl[i].exp_hit));
         check($sformatf("fwd_conflict[%0d]", i), 32'(fwd_conflict), 32'(fwd_tbl[i].exp_conflict));
         if (fwd_tbl[i].chk_data)
            check($sformatf("fwd_data[%0d]", i), fwd_data, fwd_tbl[i].exp_data);
         tick();
      end
      // a younger word store overrides both older entries
      drive_store(32'h20, 32'h5566_7788, 1'b0);
      ld_addr = 32'h20;
      ld_byte = 1'b0;
      #1;
      check("fwd_young_word_hit",  32'(fwd_hit),      fwd_en ? 32'd1 : 32'd0);
      check("fwd_young_word_conf", 32'(fwd_conflict), fwd_en ? 32'd0 : 32'd1);
      check("fwd_young_word_data", fwd_data,          fwd_en ? 32'h5566_7788 : 32'h0);
      ld_addr = 32'h21;
      ld_byte = 1'b1;
      #1;
      check("fwd_young_byte_data", fwd_data, fwd_en ? 32'h0000_0077 : 32'h0);
      mem_ack = 1'b1;
      repeat (3) tick();
      mem_ack = 1'b0;
      check("t3_empty", 32'(empty), 32'd1);

      // ---------------- flush with three entries ----------------
      drive_store(32'h200, 32'h0000_0200, 1'b0);
      drive_store(32'h204, 32'h0000_0204, 1'b0);
      drive_store(32'h208, 32'h0000_0208, 1'b1);
      flush = 1'b1;
      tick();
      check("fl_ready_in_flush", 32'(st_ready),   32'd0);
      check("fl_done_early",     32'(flush_done), 32'd0);
      tick();
      check("fl_ready_hold",     32'(st_ready),   32'd0);
      mem_ack = 1'b1;
      pulses  = 0;
      for (int c = 0; c < 5; c++) begin
         tick();
         check($sformatf("fl_done_c%0d", c),  32'(flush_done), 32'(c == 2));
         check($sformatf("fl_ready_c%0d", c), 32'(st_ready),   32'(c >= 2));
         if (flush_done) begin
            pulses++;
            flush = 1'b0;
         end
      end
      flush   = 1'b0;
      mem_ack = 1'b0;
      check("fl_pulse_count", 32'(pulses), 32'd1);
      check("fl_empty",       32'(empty),  32'd1);

      // ---------------- flush while already empty ----------------
      flush = 1'b1;
      tick();
      check("fle_ready_in_flush", 32'(st_ready),   32'd0);
      check("fle_done_first",     32'(flush_done), 32'd0);
      tick();
      check("fle_done_pulse",     32'(flush_done), 32'd1);
      check("fle_ready_back",     32'(st_ready),   32'd1);
      flush = 1'b0;
      tick();
      check("fle_done_clear",     32'(flush_done), 32'd0);

      // ---------------- push and pop together, then reset mid-drain -------
      drive_store(32'h300, 32'h0000_0300, 1'b0);
      drive_store(32'h304, 32'h0000_0304, 1'b0);
      check("pp_count_before", 32'(count), 32'd2);
      st_valid = 1'b1;
      st_addr  = 32'h308;
      st_data  = 32'h0000_0308;
      st_byte  = 1'b0;
      mem_ack  = 1'b1;
      tick();
      st_valid = 1'b0;
      mem_ack  = 1'b0;
      check("pp_count_same", 32'(count), 32'd2);
      check("pp_head_moved", mem_addr,   32'h304);
      check("rm_req_before", 32'(mem_req), 32'd1);
      rst_n = 1'b0;
      tick();
      check("rm_count",    32'(count),    32'd0);
      check("rm_mem_req",  32'(mem_req),  32'd0);
      check("rm_empty",    32'(empty),    32'd1);
      check("rm_st_ready", 32'(st_ready), 32'd1);
      rst_n = 1'b1;

      // ---------------- single entry, forwarded while being popped --------
      drive_store(32'h40, 32'hCAFE_F00D, 1'b0);
      ld_addr = 32'h40;
      ld_byte = 1'b0;
      mem_ack = 1'b1;
      #1;
      check("w40_hit",  32'(fwd_hit),      fwd_en ? 32'd1 : 32'd0);
      check("w40_conf", 32'(fwd_conflict), fwd_en ? 32'd0 : 32'd1);
      check("w40_data", fwd_data,          fwd_en ? 32'hCAFE_F00D : 32'h0);
      tick();
      mem_ack = 1'b0;
      check("w40_after_hit",  32'(fwd_hit),      32'd0);
      check("w40_after_conf", 32'(fwd_conflict), 32'd0);
      check("w40_after_data", fwd_data,          32'h0);
      check("w40_empty",      32'(empty),        32'd1);

      tick();
      check("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/store_buffer.md
# store_buffer

Write-side companion to the data cache/memory read path. Retires core stores into a small FIFO and drains them one word or byte at a time to main memory over a req/ack handshake. Forwards buffered store data to younger loads so reads stay coherent with stores that have not yet drained. Sits between the core's memory stage and `data_memory`'s write port, alongside the cache read mux.

## Interface
- `DATA_WIDTH`, 32, data and address width.
- `DEPTH`, 4, number of buffer entries; power of two, ≥2.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `st_valid`  in  1  core offers a store.
- `st_ready`  out  1  buffer accepts; a store transfers when `st_valid && st_ready`.
- `st_addr`  in  DATA_WIDTH  store byte address.
- `st_data`  in  DATA_WIDTH  store data; a byte store uses bits [7:0].
- `st_byte`  in  1  1 = byte store, 0 = word store.
- `flush`  in  1  request to drain fully (level).
- `flush_done`  out  1  one-cycle pulse when a flush completes.
- `ld_addr`  in  DATA_WIDTH  load address to check.
- `ld_byte`  in  1  1 = byte load.
- `fwd_hit`  out  1  `fwd_data` is valid for this load (combinational).
- `fwd_data`  out  DATA_WIDTH  forwarded load data; byte loads are zero-extended.
- `fwd_conflict`  out  1  partial overlap; core must stall the load (combinational).
- `mem_req`  out  1  write request to memory.
- `mem_ack`  in  1  memory accepted the head entry.
- `mem_addr`, `mem_wdata`  out  DATA_WIDTH  head entry address and data.
- `mem_byte`  out  1  head entry size.
- `count`  out  $clog2(DEPTH)+1  occupancy.
- `empty`, `full`  out  1  occupancy flags.

## Operation
- FIFO: circular, with head/tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH. Push at the tail, pop at the head.
- `st_ready = !full && state==RUN`.
- Push and pop in the same cycle: `count` is unchanged. A push is never accepted when full, even if a pop happens in the same cycle.
- Drain:
  - `mem_req = !empty`.
  - `mem_addr`, `mem_wdata` and `mem_byte` come from the head entry and stay stable until acknowledged.
  - The head pops on any edge where `mem_req && mem_ack`.
  - `mem_ack` while `mem_req` is low is ignored.
- FSM states:
  - RUN → FLUSH when `flush` is high.
  - FLUSH: `st_ready` is 0. FLUSH → RUN on the edge where the buffer becomes, or already is, empty. `flush_done` pulses for one cycle on that transition.
  - `flush` asserted while the buffer is empty: FLUSH is entered for one cycle, then `flush_done` pulses.
- Forwarding match: an entry matches when entry `addr[31:2] == ld_addr[31:2]`. Only the youngest matching entry is considered.
  - Youngest match is a word store: `fwd_hit` = 1. A word load gets the full word. A byte load gets byte lane `ld_addr[1:0]`, zero-extended.
  - Youngest match is a byte store, byte load, same `addr[1:0]`: `fwd_hit` = 1 with the stored byte.
  - Youngest match is a byte store and a byte load at a different lane: ignore that entry and continue the search with the next-older match.
  - Youngest match is a byte store and the load is a word load: `fwd_conflict` = 1 and `fwd_hit` = 0.
  - No match: `fwd_hit` = 0, `fwd_conflict` = 0, `fwd_data` = 0.
- An entry being popped this cycle still participates in forwarding this cycle.

## Timing
- Reset (`rst_n` = 0 at an edge):
  - Pointers cleared, `count` = 0, `empty` = 1, `full` = 0.
  - `mem_req` = 0, `flush_done` = 0, state = RUN.
  - `st_ready` = 1 from the first cycle after reset.
  - Reset mid-drain discards all entries; `mem_req` is low after that edge.
- Push-to-request latency is one cycle: a store accepted at edge N appears as `mem_req` after edge N when the buffer was empty.
- Drain throughput is one entry per cycle while `mem_ack` is held high.
- `count`, `empty` and `full` are registered and reflect the state after each edge.
- Forwarding outputs are combinational from `ld_addr`/`ld_byte` and the entry registers; there are no other combinational paths to outputs.

## Configuration
- `STORE_FWD_EN` defined: forwarding logic is present as described above.
- `STORE_FWD_EN` undefined:
  - `fwd_hit` and `fwd_data` are tied to 0.
  - `fwd_conflict` = 1 whenever any entry matches `ld_addr[31:2]`, regardless of size.
  - The core stalls until the matching entry drains.

## Test plan
- Reset, push a word store to 0x100 with data 0xDEADBEEF and `mem_ack` held high → `mem_req` is high for exactly one cycle with addr 0x100 and data 0xDEADBEEF, then `empty` = 1.
- With `mem_ack` = 0, push stores to 0x0, 0x4, 0x8, 0xC → `full` = 1, `count` = 4, `st_ready` = 0. A fifth push is refused. Raise `mem_ack` → pops occur in order 0x0, 0x4, 0x8, 0xC, confirming pointer wrap.
- Forwarding:
  - Word store to 0x20 with 0x11223344, then byte store to 0x21 with 0xAA.
  - Byte load at 0x21 → `fwd_data` = 0xAA.
  - Byte load at 0x22 → `fwd_data` = 0x22.
  - Word load at 0x20 → `fwd_conflict` = 1.
- Three buffered entries, assert `flush` → `st_ready` = 0 until empty. `flush_done` pulses once, on the cycle after the third ack.
- Push and pop in the same cycle at `count` = 2 → `count` stays 2. Pulse `rst_n` low while `mem_req` = 1 → `count` = 0 and `mem_req` = 0 after that edge.
- Build without `STORE_FWD_EN`, word store to 0x40, word load at 0x40 → `fwd_hit` = 0 and `fwd_conflict` = 1.
